// File: rtl/ddr_avalon_port_arbiter.sv
// ddr_avalon_port_arbiter
// Round-robin arbiter that lets several local Avalon-MM masters share the
// single Avalon-MM slave port of the DDR3 controller. Write bursts are locked
// to their owner; read returns are steered back in order through a small
// FIFO of {port, burstcount} records.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | arbitrate every cycle; reads and single writes complete here
// ST_WBURST | remaining beats of a write burst, only the owner passes

module ddr_avalon_port_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 25,
    parameter int BURST_W   = 3,
    parameter int MAX_PEND  = 8
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]     s_address_i,
    input  logic [NUM_PORTS-1:0]            s_read_i,
    input  logic [NUM_PORTS-1:0]            s_write_i,
    input  logic [NUM_PORTS*DATA_W-1:0]     s_writedata_i,
    input  logic [NUM_PORTS*DATA_W/8-1:0]   s_byteenable_i,
    input  logic [NUM_PORTS*BURST_W-1:0]    s_burstcount_i,
    output logic [NUM_PORTS-1:0]            s_waitrequest_o,
    output logic [DATA_W-1:0]               s_readdata_o,
    output logic [NUM_PORTS-1:0]            s_readdatavalid_o,
    output logic [ADDR_W-1:0]               m_address_o,
    output logic                            m_read_o,
    output logic                            m_write_o,
    output logic [DATA_W-1:0]               m_writedata_o,
    output logic [DATA_W/8-1:0]             m_byteenable_o,
    output logic [BURST_W-1:0]              m_burstcount_o,
    input  logic                            m_waitrequest_i,
    input  logic [DATA_W-1:0]               m_readdata_i,
    input  logic                            m_readdatavalid_i,
    output logic                            err_unexpected_rdv_o
);

    localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int BE_W = DATA_W / 8;
    localparam int FW   = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
    localparam int CW   = FW + 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_WBURST = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [BURST_W-1:0]   beats_left_q, beats_left_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [BURST_W-1:0]   rd_beat_q, rd_beat_d;
    logic                 err_q, err_d;

    logic [PW-1:0]        fifo_port_q  [MAX_PEND];
    logic [BURST_W-1:0]   fifo_burst_q [MAX_PEND];
    logic [FW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;

    logic [NUM_PORTS-1:0] elig;
    logic                 win_found;
    logic [PW-1:0]        win_idx;
    logic [PW-1:0]        sel;
    logic [BURST_W-1:0]   sel_bc_raw;
    logic [BURST_W-1:0]   sel_bc;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 rdv_hit;
    logic [PW-1:0]        head_port;
    logic [BURST_W-1:0]   head_burst;

    // (base + off) modulo NUM_PORTS, valid for base < NUM_PORTS and off <= NUM_PORTS
    function automatic logic [PW-1:0] wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NUM_PORTS) s = s - NUM_PORTS;
        return PW'(s);
    endfunction

    assign fifo_full  = (count_q == CW'(MAX_PEND));
    assign fifo_empty = (count_q == '0);
    assign head_port  = fifo_port_q[rd_ptr_q];
    assign head_burst = fifo_burst_q[rd_ptr_q];

    // Eligibility and round-robin search starting at rr_ptr
    always_comb begin
        elig      = s_write_i | (s_read_i & {NUM_PORTS{~fifo_full}});
        win_found = 1'b0;
        win_idx   = '0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            if (!win_found && elig[wrap_idx(int'(rr_ptr_q), off)]) begin
                win_found = 1'b1;
                win_idx   = wrap_idx(int'(rr_ptr_q), off);
            end
        end
    end

    // Command mux toward the controller and per-port stall generation
    always_comb begin
        sel             = (state_q == ST_WBURST) ? owner_q : win_idx;
        sel_bc_raw      = s_burstcount_i[int'(sel)*BURST_W +: BURST_W];
        sel_bc          = (sel_bc_raw == '0) ? BURST_W'(1) : sel_bc_raw;
        m_writedata_o   = s_writedata_i[int'(sel)*DATA_W +: DATA_W];
        m_byteenable_o  = s_byteenable_i[int'(sel)*BE_W +: BE_W];
        m_address_o     = s_address_i[int'(sel)*ADDR_W +: ADDR_W];
        m_burstcount_o  = sel_bc;
        m_read_o        = 1'b0;
        m_write_o       = 1'b0;
        s_waitrequest_o = '1;
        if (state_q == ST_WBURST) begin
            // address and length stay at the first-beat values for the whole burst
            m_address_o          = addr_q;
            m_burstcount_o       = burst_q;
            m_write_o            = s_write_i[owner_q];
            s_waitrequest_o[sel] = m_waitrequest_i;
        end else if (win_found) begin
            // a port raising both strobes is a write
            m_write_o            = s_write_i[sel];
            m_read_o             = ~s_write_i[sel];
            s_waitrequest_o[sel] = m_waitrequest_i;
        end
        if (!reset_n_i) begin
            m_read_o        = 1'b0;
            m_write_o       = 1'b0;
            s_waitrequest_o = '1;
        end
    end

    assign accept = (m_read_o | m_write_o) & ~m_waitrequest_i;
    assign push   = accept & m_read_o;

    // Read-return steering from the FIFO head
    always_comb begin
        s_readdata_o      = m_readdata_i;
        s_readdatavalid_o = '0;
        rdv_hit           = m_readdatavalid_i & ~fifo_empty;
        pop               = 1'b0;
        rd_beat_d         = rd_beat_q;
        err_d             = err_q | (m_readdatavalid_i & fifo_empty);
        if (rdv_hit) begin
            s_readdatavalid_o[head_port] = 1'b1;
            if ((rd_beat_q + 1'b1) == head_burst) begin
                pop       = 1'b1;
                rd_beat_d = '0;
            end else begin
                rd_beat_d = rd_beat_q + 1'b1;
            end
        end
    end

    // Next-state logic for arbitration, burst lock and FIFO pointers
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        beats_left_d = beats_left_q;
        addr_d       = addr_q;
        burst_d      = burst_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + CW'(push) - CW'(pop);
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rr_ptr_d = wrap_idx(int'(win_idx), 1);
                    if (m_write_o && (sel_bc > BURST_W'(1))) begin
                        state_d      = ST_WBURST;
                        owner_d      = win_idx;
                        beats_left_d = sel_bc - 1'b1;
                        addr_d       = m_address_o;
                        burst_d      = sel_bc;
                    end
                end
            end
            ST_WBURST: begin
                if (accept) begin
                    beats_left_d = beats_left_q - 1'b1;
                    if (beats_left_q == BURST_W'(1)) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            beats_left_q <= '0;
            addr_q       <= '0;
            burst_q      <= '0;
            rd_beat_q    <= '0;
            err_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            beats_left_q <= beats_left_d;
            addr_q       <= addr_d;
            burst_q      <= burst_d;
            rd_beat_q    <= rd_beat_d;
            err_q        <= err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // FIFO payload storage; contents are don't-care while count is zero
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_port_q[wr_ptr_q]  <= win_idx;
            fifo_burst_q[wr_ptr_q] <= sel_bc;
        end
    end

    assign err_unexpected_rdv_o = err_q;

endmodule

// File: tb/tb_ddr_avalon_port_arbiter.sv
// Directed bench for ddr_avalon_port_arbiter with hand-computed expectations.

module tb_ddr_avalon_port_arbiter;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int AW = 25;
    localparam int BW = 3;
    localparam int MP = 8;

    logic               clk_i = 1'b0;
    logic               reset_n_i;
    logic [NP*AW-1:0]   s_address_i;
    logic [NP-1:0]      s_read_i;
    logic [NP-1:0]      s_write_i;
    logic [NP*DW-1:0]   s_writedata_i;
    logic [NP*DW/8-1:0] s_byteenable_i;
    logic [NP*BW-1:0]   s_burstcount_i;
    logic [NP-1:0]      s_waitrequest_o;
    logic [DW-1:0]      s_readdata_o;
    logic [NP-1:0]      s_readdatavalid_o;
    logic [AW-1:0]      m_address_o;
    logic               m_read_o;
    logic               m_write_o;
    logic [DW-1:0]      m_writedata_o;
    logic [DW/8-1:0]    m_byteenable_o;
    logic [BW-1:0]      m_burstcount_o;
    logic               m_waitrequest_i;
    logic [DW-1:0]      m_readdata_i;
    logic               m_readdatavalid_i;
    logic               err_unexpected_rdv_o;

    int passes = 0;
    int total  = 0;

    ddr_avalon_port_arbiter #(
        .NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .BURST_W(BW), .MAX_PEND(MP)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .s_address_i(s_address_i), .s_read_i(s_read_i), .s_write_i(s_write_i),
        .s_writedata_i(s_writedata_i), .s_byteenable_i(s_byteenable_i),
        .s_burstcount_i(s_burstcount_i), .s_waitrequest_o(s_waitrequest_o),
        .s_readdata_o(s_readdata_o), .s_readdatavalid_o(s_readdatavalid_o),
        .m_address_o(m_address_o), .m_read_o(m_read_o), .m_write_o(m_write_o),
        .m_writedata_o(m_writedata_o), .m_byteenable_o(m_byteenable_o),
        .m_burstcount_o(m_burstcount_o), .m_waitrequest_i(m_waitrequest_i),
        .m_readdata_i(m_readdata_i), .m_readdatavalid_i(m_readdatavalid_i),
        .err_unexpected_rdv_o(err_unexpected_rdv_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_port(input int p, input logic rd, input logic wr,
                            input logic [AW-1:0] addr, input logic [BW-1:0] bc);
        s_read_i[p]               = rd;
        s_write_i[p]              = wr;
        s_address_i[p*AW +: AW]   = addr;
        s_burstcount_i[p*BW +: BW] = bc;
        s_writedata_i[p*DW +: DW] = {32'hD0D0_0000, 32'(p)};
        s_byteenable_i[p*8 +: 8]  = 8'hFF;
    endtask

    task automatic clear_ports();
        s_read_i       = '0;
        s_write_i      = '0;
        s_address_i    = '0;
        s_writedata_i  = '0;
        s_byteenable_i = '0;
        s_burstcount_i = '0;
    endtask

    initial begin
        clear_ports();
        m_waitrequest_i   = 1'b0;
        m_readdata_i      = '0;
        m_readdatavalid_i = 1'b0;
        reset_n_i         = 1'b0;

        // reset: outputs forced idle even with a request present
        set_port(0, 1'b0, 1'b1, 25'h100, 3'd1);
        tick();
        tick();
        #1;
        chk("rst_m_write", m_write_o, 1'b0);
        chk("rst_m_read", m_read_o, 1'b0);
        chk("rst_swait", s_waitrequest_o, 4'hF);
        chk("rst_err", err_unexpected_rdv_o, 1'b0);
        chk("rst_rr", dut.rr_ptr_q, 2'd0);
        clear_ports();
        reset_n_i = 1'b1;
        tick();

        // alternating single writes on ports 0 and 2
        set_port(0, 1'b0, 1'b1, 25'h100, 3'd1);
        set_port(2, 1'b0, 1'b1, 25'h200, 3'd1);
        #1;
        chk("rr_g0_swait", s_waitrequest_o, 4'b1110);
        chk("rr_g0_addr", m_address_o, 25'h100);
        chk("rr_g0_wdata", m_writedata_o, 64'hD0D0_0000_0000_0000);
        tick();
        chk("rr_ptr_after_g0", dut.rr_ptr_q, 2'd1);
        chk("rr_g1_swait", s_waitrequest_o, 4'b1011);
        chk("rr_g1_addr", m_address_o, 25'h200);
        tick();
        chk("rr_g2_swait", s_waitrequest_o, 4'b1110);
        tick();
        chk("rr_g3_swait", s_waitrequest_o, 4'b1011);
        chk("rr_g3_write", m_write_o, 1'b1);
        tick();
        chk("rr_ptr_after_4", dut.rr_ptr_q, 2'd3);
        clear_ports();

        // port 1 write burst of 4, port 3 waits for the burst to finish
        set_port(1, 1'b0, 1'b1, 25'h040, 3'd4);
        #1;
        chk("wb_b1_swait", s_waitrequest_o, 4'b1101);
        chk("wb_b1_bc", m_burstcount_o, 3'd4);
        tick();
        set_port(3, 1'b0, 1'b1, 25'h300, 3'd1);
        s_address_i[1*AW +: AW] = 25'h1FFF;
        for (int b = 2; b <= 4; b++) begin
            #1;
            chk($sformatf("wb_b%0d_swait", b), s_waitrequest_o, 4'b1101);
            chk($sformatf("wb_b%0d_addr", b), m_address_o, 25'h040);
            chk($sformatf("wb_b%0d_bc", b), m_burstcount_o, 3'd4);
            tick();
        end
        s_write_i[1] = 1'b0;
        #1;
        chk("wb_p3_swait", s_waitrequest_o, 4'b0111);
        chk("wb_p3_addr", m_address_o, 25'h300);
        tick();
        chk("wb_rr_after", dut.rr_ptr_q, 2'd0);
        clear_ports();

        // port 0 read burst 2, port 3 read burst 1, then three returns
        set_port(0, 1'b1, 1'b0, 25'h010, 3'd2);
        #1;
        chk("rd0_read", m_read_o, 1'b1);
        chk("rd0_swait", s_waitrequest_o, 4'b1110);
        tick();
        clear_ports();
        set_port(3, 1'b1, 1'b0, 25'h030, 3'd1);
        #1;
        chk("rd3_swait", s_waitrequest_o, 4'b0111);
        tick();
        clear_ports();
        m_readdatavalid_i = 1'b1;
        m_readdata_i      = 64'hAAAA_0001;
        #1;
        chk("ret1_rdv", s_readdatavalid_o, 4'b0001);
        chk("ret1_data", s_readdata_o, 64'hAAAA_0001);
        tick();
        m_readdata_i = 64'hAAAA_0002;
        #1;
        chk("ret2_rdv", s_readdatavalid_o, 4'b0001);
        tick();
        m_readdata_i = 64'hBBBB_0003;
        #1;
        chk("ret3_rdv", s_readdatavalid_o, 4'b1000);
        chk("ret3_data", s_readdata_o, 64'hBBBB_0003);
        tick();
        m_readdatavalid_i = 1'b0;
        #1;
        chk("ret_fifo_empty", dut.count_q, 4'd0);
        chk("ret_no_err", err_unexpected_rdv_o, 1'b0);

        // fill the FIFO with port 2 single reads
        set_port(2, 1'b1, 1'b0, 25'h020, 3'd1);
        for (int i = 0; i < MP; i++) tick();
        set_port(1, 1'b0, 1'b1, 25'h011, 3'd1);
        #1;
        chk("full_swait", s_waitrequest_o, 4'b1101);
        chk("full_write", m_write_o, 1'b1);
        chk("full_read", m_read_o, 1'b0);
        tick();
        s_write_i[1] = 1'b0;
        m_readdatavalid_i = 1'b1;
        #1;
        chk("full_pop_stall", s_waitrequest_o, 4'hF);
        chk("full_pop_mread", m_read_o, 1'b0);
        chk("full_pop_rdv", s_readdatavalid_o, 4'b0100);
        tick();
        m_readdatavalid_i = 1'b0;
        #1;
        chk("unblock_swait", s_waitrequest_o, 4'b1011);
        chk("unblock_read", m_read_o, 1'b1);
        tick();
        clear_ports();
        m_readdatavalid_i = 1'b1;
        for (int i = 0; i < MP; i++) begin
            #1;
            chk($sformatf("drain%0d_rdv", i), s_readdatavalid_o, 4'b0100);
            tick();
        end
        m_readdatavalid_i = 1'b0;
        #1;
        chk("drain_empty", dut.count_q, 4'd0);
        chk("drain_no_err", err_unexpected_rdv_o, 1'b0);

        // unexpected read data with nothing outstanding
        m_readdatavalid_i = 1'b1;
        #1;
        chk("unexp_rdv", s_readdatavalid_o, 4'b0000);
        tick();
        m_readdatavalid_i = 1'b0;
        #1;
        chk("unexp_err_set", err_unexpected_rdv_o, 1'b1);
        tick();
        chk("unexp_err_sticky", err_unexpected_rdv_o, 1'b1);
        reset_n_i = 1'b0;
        tick();
        reset_n_i = 1'b1;
        #1;
        chk("unexp_err_clr", err_unexpected_rdv_o, 1'b0);

        // controller stall for five cycles
        m_waitrequest_i = 1'b1;
        set_port(1, 1'b0, 1'b1, 25'h055, 3'd1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("stall%0d_swait", i), s_waitrequest_o, 4'hF);
            chk($sformatf("stall%0d_write", i), m_write_o, 1'b1);
            tick();
            chk($sformatf("stall%0d_rr", i), dut.rr_ptr_q, 2'd0);
        end
        m_waitrequest_i = 1'b0;
        #1;
        chk("stall_accept_swait", s_waitrequest_o, 4'b1101);
        tick();
        chk("stall_rr_after", dut.rr_ptr_q, 2'd2);
        clear_ports();

        // burstcount 0 behaves as a single beat
        set_port(0, 1'b0, 1'b1, 25'h077, 3'd0);
        #1;
        chk("bc0_bc", m_burstcount_o, 3'd1);
        tick();
        chk("bc0_state", dut.state_q, 1'b0);
        chk("bc0_again_swait", s_waitrequest_o, 4'b1110);
        tick();
        clear_ports();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
